// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction/address widths, opcodes, fetch FSM encoding.
package cpu_pkg;

  localparam int XLEN = 16;
  localparam int ILEN = 16;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Instructions are 2 bytes; wraps modulo 2^16 with no carry out.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads on load_i unless stalled, flush clears, 1-cycle latency.
// Backpressure: stall_i freezes contents; flush_i has priority over stall_i.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [ILEN-1:0] instr_i,
  input  logic [XLEN-1:0] next_pc_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] next_pc_o,
  output logic            valid_o
);

  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic            valid_q, valid_d;

  always_comb begin
    instr_d   = instr_q;
    next_pc_d = next_pc_q;
    valid_d   = valid_q;
    if (flush_i) begin
      instr_d   = '0;
      next_pc_d = '0;
      valid_d   = 1'b0;
    end else if (load_i && !stall_i) begin
      instr_d   = instr_i;
      next_pc_d = next_pc_i;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      next_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      next_pc_q <= next_pc_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign next_pc_o = next_pc_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one word per cycle on zero-wait memory; a stalled ack parks in a one-entry hold buffer.
// Flush redirects and clears IF/ID; HLT stops requests. FETCH_STALL_CNT_EN adds the stall_cycles counter.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]      HLT_OPCODE = OP_HLT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] pc,
  output logic [ILEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_next_pc,
  output logic            if_id_valid,
  output logic            halted
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cycles
`endif
);

  fetch_state_e    state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_npc_q, hold_npc_d;
  logic            halted_q, halted_d;

  logic            ack_v;
  logic [XLEN-1:0] pc_plus2;
  logic            fetch_is_hlt;
  logic            hold_is_hlt;
  logic            ifid_load;
  logic [ILEN-1:0] ifid_instr_in;
  logic [XLEN-1:0] ifid_npc_in;

  // An ack only counts while a request is actually outstanding.
  assign ack_v        = req_q && imem_ack;
  assign pc_plus2     = pc_inc(pc_q);
  assign fetch_is_hlt = (imem_rdata[15:12] == HLT_OPCODE);
  assign hold_is_hlt  = (hold_instr_q[15:12] == HLT_OPCODE);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    hold_npc_d    = hold_npc_q;
    halted_d      = halted_q;
    ifid_load     = 1'b0;
    ifid_instr_in = imem_rdata;
    ifid_npc_in   = pc_plus2;
    if (flush) begin
      state_d      = ST_FETCH;
      pc_d         = br_target;
      hold_instr_d = '0;
      hold_npc_d   = '0;
      halted_d     = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (ack_v) begin
            // HLT parks the PC on itself so a later redirect is the only way out.
            if (!fetch_is_hlt) pc_d = pc_plus2;
            if (stall) begin
              hold_instr_d = imem_rdata;
              hold_npc_d   = pc_plus2;
              state_d      = ST_HOLD;
            end else begin
              ifid_load = 1'b1;
              if (fetch_is_hlt) begin
                state_d  = ST_HALT;
                halted_d = 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ifid_load     = 1'b1;
            ifid_instr_in = hold_instr_q;
            ifid_npc_in   = hold_npc_q;
            state_d       = hold_is_hlt ? ST_HALT : ST_FETCH;
            halted_d      = hold_is_hlt;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_d = (state_d == ST_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      req_q        <= 1'b0;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_npc_q   <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_npc_q   <= hold_npc_d;
      halted_q     <= halted_d;
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .stall_i   (stall),
    .load_i    (ifid_load),
    .instr_i   (ifid_instr_in),
    .next_pc_i (ifid_npc_in),
    .instr_o   (if_id_instr),
    .next_pc_o (if_id_next_pc),
    .valid_o   (if_id_valid)
  );

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((req_q && !imem_ack) || (state_q == ST_HOLD)) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table on a default-PC instance, hand sequence on a 0xFFFE-PC instance.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic        ack, stall, flush;
  logic [15:0] rdata, tgt;

  logic        req, vld, hlt;
  logic [15:0] addr, pc, instr, npc;

  logic        req2, vld2, hlt2;
  logic [15:0] addr2, pc2, instr2, npc2, rdata2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
    .stall(stall), .flush(flush), .br_target(tgt),
    .pc(pc), .if_id_instr(instr), .if_id_next_pc(npc), .if_id_valid(vld),
    .halted(hlt)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cycles()
`endif
  );

  // Zero-wait memory for the wrap instance: ack follows request, word = {1, addr[11:0]}.
  assign rdata2 = {4'h1, addr2[11:0]};

  fetch_stage #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst_n(rst2_n),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(req2), .imem_rdata(rdata2),
    .stall(1'b0), .flush(1'b0), .br_target(16'h0000),
    .pc(pc2), .if_id_instr(instr2), .if_id_next_pc(npc2), .if_id_valid(vld2),
    .halted(hlt2)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cycles()
`endif
  );

  typedef struct {
    logic        ack;
    logic [15:0] rdata;
    logic        stall;
    logic        flush;
    logic [15:0] tgt;
    logic        e_req;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic [15:0] e_npc;
    logic        e_vld;
    logic        e_hlt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic a, input logic [15:0] d, input logic s, input logic f,
                              input logic [15:0] t, input logic er, input logic [15:0] ep,
                              input logic [15:0] ei, input logic [15:0] en, input logic ev,
                              input logic eh);
    vec_t v;
    v.ack = a; v.rdata = d; v.stall = s; v.flush = f; v.tgt = t;
    v.e_req = er; v.e_pc = ep; v.e_instr = ei; v.e_npc = en; v.e_vld = ev; v.e_hlt = eh;
    vq.push_back(v);
  endfunction

  initial begin
    //   ack rdata     stl fl  tgt       | req pc        instr     npc       vld hlt
    add(0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0000, 16'h0000, 16'h0000, 0, 0); // first request
    add(1, 16'h1000, 0, 0, 16'h0000,   1, 16'h0002, 16'h1000, 16'h0002, 1, 0);
    add(1, 16'h1001, 0, 0, 16'h0000,   1, 16'h0004, 16'h1001, 16'h0004, 1, 0);
    add(1, 16'h1002, 0, 0, 16'h0000,   1, 16'h0006, 16'h1002, 16'h0006, 1, 0);
    add(0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0006, 16'h1002, 16'h0006, 1, 0); // wait state
    add(1, 16'h2003, 1, 0, 16'h0000,   0, 16'h0008, 16'h1002, 16'h0006, 1, 0); // ack under stall
    add(1, 16'hDEAD, 1, 0, 16'h0000,   0, 16'h0008, 16'h1002, 16'h0006, 1, 0);
    add(0, 16'h0000, 1, 0, 16'h0000,   0, 16'h0008, 16'h1002, 16'h0006, 1, 0);
    add(0, 16'h0000, 0, 0, 16'h0000,   1, 16'h0008, 16'h2003, 16'h0008, 1, 0); // release hold
    add(1, 16'h3004, 1, 1, 16'h0040,   1, 16'h0040, 16'h0000, 16'h0000, 0, 0); // flush+stall+ack
    add(1, 16'h4000, 0, 0, 16'h0000,   1, 16'h0042, 16'h4000, 16'h0042, 1, 0);
    add(0, 16'h0000, 0, 1, 16'h0006,   1, 16'h0006, 16'h0000, 16'h0000, 0, 0);
    add(1, 16'hF000, 0, 0, 16'h0000,   0, 16'h0006, 16'hF000, 16'h0008, 1, 1); // HLT
    add(1, 16'h1234, 0, 0, 16'h0000,   0, 16'h0006, 16'hF000, 16'h0008, 1, 1);
    add(0, 16'h0000, 1, 0, 16'h0000,   0, 16'h0006, 16'hF000, 16'h0008, 1, 1);
    add(0, 16'h0000, 0, 1, 16'h0010,   1, 16'h0010, 16'h0000, 16'h0000, 0, 0); // resume
    add(1, 16'h5005, 0, 0, 16'h0000,   1, 16'h0012, 16'h5005, 16'h0012, 1, 0);
    add(0, 16'h0000, 0, 1, 16'h0100,   1, 16'h0100, 16'h0000, 16'h0000, 0, 0); // abandon request
    add(1, 16'hF001, 1, 0, 16'h0000,   0, 16'h0100, 16'h0000, 16'h0000, 0, 0); // HLT into hold
    add(0, 16'h0000, 0, 0, 16'h0000,   0, 16'h0100, 16'hF001, 16'h0102, 1, 1);
    add(0, 16'h0000, 0, 1, 16'hFFFE,   1, 16'hFFFE, 16'h0000, 16'h0000, 0, 0);
    add(1, 16'h6006, 0, 0, 16'h0000,   1, 16'h0000, 16'h6006, 16'h0000, 1, 0); // wrap
    add(1, 16'h7007, 0, 0, 16'h0000,   1, 16'h0002, 16'h7007, 16'h0002, 1, 0);

    rst_n = 1'b0; rst2_n = 1'b0;
    ack = 1'b0; rdata = '0; stall = 1'b0; flush = 1'b0; tgt = '0;
    #12;
    chk("rst_req",   0, {15'd0, req}, 16'h0000);
    chk("rst_pc",    0, pc,           16'h0000);
    chk("rst_addr",  0, addr,         16'h0000);
    chk("rst_instr", 0, instr,        16'h0000);
    chk("rst_npc",   0, npc,          16'h0000);
    chk("rst_vld",   0, {15'd0, vld}, 16'h0000);
    chk("rst_hlt",   0, {15'd0, hlt}, 16'h0000);
    chk("rst2_pc",   0, pc2,          16'hFFFE);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      ack = vq[i].ack; rdata = vq[i].rdata; stall = vq[i].stall;
      flush = vq[i].flush; tgt = vq[i].tgt;
      @(posedge clk);
      #1;
      chk("req",   i, {15'd0, req}, {15'd0, vq[i].e_req});
      chk("pc",    i, pc,           vq[i].e_pc);
      chk("addr",  i, addr,         vq[i].e_pc);
      chk("instr", i, instr,        vq[i].e_instr);
      chk("npc",   i, npc,          vq[i].e_npc);
      chk("vld",   i, {15'd0, vld}, {15'd0, vq[i].e_vld});
      chk("hlt",   i, {15'd0, hlt}, {15'd0, vq[i].e_hlt});
    end
    ack = 1'b0; stall = 1'b0; flush = 1'b0;

    // Wrap instance: second address must be 0x0000, then async reset clears IF/ID mid-request.
    @(negedge clk);
    rst2_n = 1'b1;
    @(posedge clk); #1;
    chk("w_req1",   0, {15'd0, req2}, 16'h0001);
    chk("w_addr1",  0, addr2,         16'hFFFE);
    @(posedge clk); #1;
    chk("w_instr1", 0, instr2,        16'h1FFE);
    chk("w_npc1",   0, npc2,          16'h0000);
    chk("w_addr2",  0, addr2,         16'h0000);
    @(posedge clk); #1;
    chk("w_instr2", 0, instr2,        16'h1000);
    chk("w_npc2",   0, npc2,          16'h0002);
    chk("w_vld2",   0, {15'd0, vld2}, 16'h0001);
    @(negedge clk);
    rst2_n = 1'b0;
    #1;
    chk("w_rvld",   0, {15'd0, vld2}, 16'h0000);
    chk("w_rinstr", 0, instr2,        16'h0000);
    chk("w_rnpc",   0, npc2,          16'h0000);
    chk("w_rreq",   0, {15'd0, req2}, 16'h0000);
    chk("w_rpc",    0, pc2,           16'hFFFE);
    @(negedge clk);
    rst2_n = 1'b1;
    @(posedge clk); #1;
    chk("w_req3",   0, {15'd0, req2}, 16'h0001);
    chk("w_addr3",  0, addr2,         16'hFFFE);
    chk("w_hlt3",   0, {15'd0, hlt2}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC loaded on reset.
REQ-002 Parameter HLT_OPCODE, default 4'hF: opcode in instr[15:12] that halts fetch.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  instruction-memory request; held high with imem_addr stable until imem_ack.
REQ-006 imem_addr  output  16  byte address of requested instruction; equals pc.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle; ignored when imem_req is low.
REQ-008 imem_rdata  input  16  fetched instruction word.
REQ-009 stall  input  1  hazard unit: hold IF/ID contents.
REQ-010 flush  input  1  taken branch/jump resolved downstream: redirect fetch.
REQ-011 br_target  input  16  redirect address, valid with flush.
REQ-012 pc  output  16  current fetch PC.
REQ-013 if_id_instr  output  16  registered instruction to decode stage.
REQ-014 if_id_next_pc  output  16  registered PC+2 of that instruction, drives decode next_i.
REQ-015 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-016 halted  output  1  HLT fetched; no further requests.

Function
REQ-017 States: FETCH (imem_req=1), HOLD (word buffered, imem_req=0), HALT (imem_req=0).
REQ-018 FETCH, ack=1, stall=0, flush=0: IF/ID <= {imem_rdata, pc+2, valid=1}; pc <= pc+2; stay FETCH. Zero-wait memory yields one instruction per cycle.
REQ-019 FETCH, ack=1, stall=1, flush=0: word and pc+2 captured in one-entry hold buffer; pc <= pc+2; IF/ID unchanged; go HOLD.
REQ-020 HOLD, stall=0, flush=0: IF/ID <= hold buffer, valid=1; go FETCH (or HALT if buffered word is HLT).
REQ-021 HOLD, stall=1: buffer and IF/ID unchanged; no request issued.
REQ-022 FETCH, ack=0: pc and IF/ID unchanged (stall still freezes IF/ID).
REQ-023 Fetched word with instr[15:12]==HLT_OPCODE: delivered to IF/ID like any instruction; pc not incremented; next state HALT; halted=1 from that edge.
REQ-024 flush=1 in any state has priority over stall and ack: pc <= br_target; if_id_valid <= 0, if_id_instr <= 16'h0000; hold buffer discarded; word acked same cycle discarded; halted <= 0; next state FETCH.
REQ-025 flush during outstanding request: imem_addr changes to br_target next cycle; memory must tolerate request abandonment (no ack for old address is consumed).
REQ-026 Arithmetic: pc+2 modulo 2^16; 16'hFFFE wraps to 16'h0000 with no flag.
REQ-027 HALT: persists until flush or reset; IF/ID holds the HLT word under stall, else retains it.

Reset
REQ-028 rst_n low asynchronously forces: pc=RESET_PC, state FETCH but imem_req=0 while rst_n low, IF/ID={16'h0000,16'h0000,valid 0}, hold buffer empty, halted=0, stall counter 0.
REQ-029 First request issued on the first rising edge after rst_n deasserts; reset mid-request abandons it.

Configuration
REQ-030 Macro FETCH_STALL_CNT_EN defined: output stall_cycles (16-bit) counts cycles with imem_req=1 and imem_ack=0 or state HOLD, saturating at 16'hFFFF, cleared by reset only.
REQ-031 Macro undefined: stall_cycles port and counter absent; all other behaviour identical.

Structure
REQ-032 Shared package cpu_pkg holds: opcode constants (including HLT), fetch state encoding, instruction/address width constants (16).
REQ-033 One sub-module, if_id_reg: IF/ID pipeline register with stall hold, flush clear, async active-low reset.

Verification
REQ-034 Reset, zero-wait memory, words 0x1000.. at 0,2,4: if_id_instr sequence 0x1000,0x1001,0x1002 on consecutive cycles, if_id_next_pc 2,4,6.
REQ-035 ack on cycle with stall=1 for 3 cycles: IF/ID frozen, HOLD entered, imem_req=0; stall drop -> buffered word in IF/ID next edge, pc advanced by exactly 2.
REQ-036 flush with br_target=0x0040 coincident with stall and ack: if_id_valid=0 next cycle, imem_addr=0x0040, acked word discarded.
REQ-037 Word 0xF000 at 0x0006: delivered valid, halted=1, imem_req=0 thereafter, pc=0x0006; flush to 0x0010 resumes fetch, halted=0.
REQ-038 RESET_PC=16'hFFFE, zero-wait: second request address 0x0000; rst_n pulsed low mid-request clears IF/ID immediately (asynchronously).
